// File: rtl/uart_pkg.sv
// uart_pkg: constants and transmit FSM state encoding shared by the UART blocks.
package uart_pkg;
  localparam int CLKS_PER_BIT_DEFAULT = 434;
  localparam logic [2:0] ST_IDLE_ENC   = 3'd0;
  localparam logic [2:0] ST_START_ENC  = 3'd1;
  localparam logic [2:0] ST_DATA_ENC   = 3'd2;
  localparam logic [2:0] ST_PARITY_ENC = 3'd3;
  localparam logic [2:0] ST_STOP_ENC   = 3'd4;
  typedef enum logic [2:0] {
    ST_IDLE   = ST_IDLE_ENC,
    ST_START  = ST_START_ENC,
    ST_DATA   = ST_DATA_ENC,
    ST_PARITY = ST_PARITY_ENC,
    ST_STOP   = ST_STOP_ENC
  } tx_state_t;
  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction
endpackage

// File: rtl/uart_tx_if.sv
// uart_tx_if: byte valid/ready handshake into the UART transmitter.
interface uart_tx_if;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  modport master (output tx_valid, tx_data, input tx_ready);
  modport slave  (input tx_valid, tx_data, output tx_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous FIFO with combinational head read and occupancy count.
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clock_50M,
  input  logic                     n_rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full    = count == CW'(DEPTH);
  assign empty   = count == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];
  always_ff @(posedge clock_50M)
    if (do_push) mem[wr_ptr] <= din;
  // depth is a power of two, so pointers wrap naturally; count tells full from empty
  always_ff @(posedge clock_50M or negedge n_rst)
    if (!n_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      count  <= count + CW'(do_push) - CW'(do_pop);
    end
endmodule

// File: rtl/uart_tx.sv
// uart_tx: FIFO-buffered 8N1 UART transmitter; define UART_TX_PARITY_EN for 8E1 framing.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                        clock_50M,
  input  logic                        n_rst,
  uart_tx_if.slave                    bus,
  output logic                        tx,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  tx_state_t state;
  logic [BW-1:0] baud;
  logic [2:0] bit_cnt;
  logic [7:0] shift, head;
  logic full, empty, push, pop, tick;
`ifdef UART_TX_PARITY_EN
  logic parity;
`endif
  assign tick         = baud == BAUD_LAST;
  assign bus.tx_ready = !full;
  assign push         = bus.tx_valid && !full;
  assign pop          = !empty && (state == ST_IDLE || (state == ST_STOP && tick));
  uart_tx_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clock_50M (clock_50M),
    .n_rst     (n_rst),
    .push      (push),
    .pop       (pop),
    .din       (bus.tx_data),
    .dout      (head),
    .full      (full),
    .empty     (empty),
    .count     (fifo_count)
  );
  // tx and busy are registered alongside the state so the line never glitches
  always_ff @(posedge clock_50M or negedge n_rst)
    if (!n_rst) begin
      state   <= ST_IDLE;
      baud    <= '0;
      bit_cnt <= '0;
      shift   <= '0;
      tx      <= 1'b1;
      busy    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity  <= 1'b0;
`endif
    end else begin
      baud <= (state == ST_IDLE || tick) ? '0 : baud + 1'b1;
      if (pop) begin
        shift   <= head;
        bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
        parity  <= even_parity(head);
`endif
      end
      case (state)
        ST_IDLE:
          if (pop) begin
            state <= ST_START;
            tx    <= 1'b0;
            busy  <= 1'b1;
          end
        ST_START:
          if (tick) begin
            state <= ST_DATA;
            tx    <= shift[0];
          end
        ST_DATA:
          if (tick) begin
            if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state <= ST_PARITY;
              tx    <= parity;
`else
              state <= ST_STOP;
              tx    <= 1'b1;
`endif
            end else begin
              shift   <= shift >> 1;
              tx      <= shift[1];
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
`ifdef UART_TX_PARITY_EN
        ST_PARITY:
          if (tick) begin
            state <= ST_STOP;
            tx    <= 1'b1;
          end
`endif
        ST_STOP:
          if (tick) begin
            state <= pop ? ST_START : ST_IDLE;
            tx    <= !pop;
            busy  <= pop;
          end
        default: begin
          state <= ST_IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed vector bench for uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4.
module tb_uart_tx;
  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME = NB * CPB;
  typedef struct {
    logic [7:0] data;
    logic       par;
  } vec_t;
  vec_t vec [20];
  logic clock_50M = 1'b0;
  logic n_rst;
  logic tx, busy;
  logic [2:0] fifo_count;
  int vectors = 0;
  int miscompares = 0;
  int stalls, peak;
  uart_tx_if bus ();
  uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
    .clock_50M  (clock_50M),
    .n_rst      (n_rst),
    .bus        (bus),
    .tx         (tx),
    .busy       (busy),
    .fifo_count (fifo_count)
  );
  always #5 clock_50M = ~clock_50M;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // Holds each byte on the bus until accepted; returns rejected edges and peak occupancy
  task automatic push_seq(input int first, input int n, output int st, output int pk);
    logic r;
    st = 0;
    pk = 0;
    for (int i = 0; i < n; i++) begin
      bus.tx_valid = 1'b1;
      bus.tx_data  = vec[first+i].data;
      forever begin
        @(negedge clock_50M);
        r = bus.tx_ready;
        @(posedge clock_50M);
        #1;
        if (int'(fifo_count) > pk) pk = int'(fifo_count);
        if (r) break;
        st++;
        if (st > 500) begin
          chk("push_timeout", 32'(st), 32'(0));
          break;
        end
      end
    end
    bus.tx_valid = 1'b0;
  endtask
  // Called #1 after the edge that starts the frame; checks every cycle of it
  task automatic check_frame(input int k);
    logic [NB-1:0] bits;
`ifdef UART_TX_PARITY_EN
    bits = {1'b1, vec[k].par, vec[k].data, 1'b0};
`else
    bits = {1'b1, vec[k].data, 1'b0};
`endif
    for (int c = 0; c < FRAME; c++) begin
      chk($sformatf("frame%0d_tx_c%0d", k, c), 32'(tx), 32'(bits[c/CPB]));
      chk($sformatf("frame%0d_busy_c%0d", k, c), 32'(busy), 32'(1));
      @(posedge clock_50M);
      #1;
    end
  endtask
  initial begin
    vec[0]  = '{8'h55, 1'b0};
    vec[1]  = '{8'h07, 1'b1};
    vec[2]  = '{8'h03, 1'b0};
    vec[3]  = '{8'hFE, 1'b1};
    vec[4]  = '{8'hA5, 1'b0};
    vec[5]  = '{8'h3C, 1'b0};
    vec[6]  = '{8'hFF, 1'b0};
    vec[7]  = '{8'h00, 1'b0};
    vec[8]  = '{8'h11, 1'b0};
    vec[9]  = '{8'h22, 1'b0};
    vec[10] = '{8'h33, 1'b0};
    vec[11] = '{8'h44, 1'b0};
    vec[12] = '{8'h5A, 1'b0};
    vec[13] = '{8'h97, 1'b1};
    vec[14] = '{8'hC3, 1'b0};
    vec[15] = '{8'h01, 1'b1};
    vec[16] = '{8'hE0, 1'b1};
    vec[17] = '{8'h81, 1'b0};
    vec[18] = '{8'h24, 1'b0};
    vec[19] = '{8'h18, 1'b0};
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
    n_rst = 1'b1;
    #2 n_rst = 1'b0;
    #1;
    chk("rst_tx", 32'(tx), 32'(1));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_ready", 32'(bus.tx_ready), 32'(1));
    chk("rst_count", 32'(fifo_count), 32'(0));
    repeat (2) @(posedge clock_50M);
    #1 n_rst = 1'b1;
    @(posedge clock_50M);
    #1;
    chk("idle_tx", 32'(tx), 32'(1));
    chk("idle_busy", 32'(busy), 32'(0));
    // single frames from idle
    for (int k = 0; k < 4; k++) begin
      push_seq(k, 1, stalls, peak);
      chk("accept_tx", 32'(tx), 32'(1));
      chk("accept_busy", 32'(busy), 32'(0));
      chk("accept_count", 32'(fifo_count), 32'(1));
      @(posedge clock_50M);
      #1;
      chk("pop_count", 32'(fifo_count), 32'(0));
      check_frame(k);
      chk("end_busy", 32'(busy), 32'(0));
      chk("end_tx", 32'(tx), 32'(1));
      repeat (3) @(posedge clock_50M);
      #1;
      chk("idle_gap_tx", 32'(tx), 32'(1));
    end
    // back-to-back frames
    fork
      push_seq(4, 4, stalls, peak);
      begin
        repeat (2) @(posedge clock_50M);
        #1;
        for (int k = 4; k < 8; k++) check_frame(k);
      end
    join
    chk("b2b_peak", 32'(peak), 32'(3));
    chk("b2b_stalls", 32'(stalls), 32'(0));
    chk("b2b_idle_busy", 32'(busy), 32'(0));
    chk("b2b_idle_count", 32'(fifo_count), 32'(0));
    repeat (3) @(posedge clock_50M);
    #1;
    // FIFO fills, sixth byte stalls until the second pop
    fork
      push_seq(8, 6, stalls, peak);
      begin
        repeat (2) @(posedge clock_50M);
        #1;
        for (int k = 8; k < 14; k++) check_frame(k);
      end
      begin
        repeat (6) @(posedge clock_50M);
        #1;
        chk("full_ready", 32'(bus.tx_ready), 32'(0));
        chk("full_count", 32'(fifo_count), 32'(4));
      end
    join
    chk("full_stalls", 32'(stalls), 32'(FRAME - 3));
    chk("full_peak", 32'(peak), 32'(4));
    chk("full_drain_count", 32'(fifo_count), 32'(0));
    repeat (3) @(posedge clock_50M);
    #1;
    // push coincides with the pop at the end of a stop bit
    fork
      begin
        push_seq(14, 2, stalls, peak);
        repeat (FRAME - 1) @(posedge clock_50M);
        #1;
        chk("pp_before_count", 32'(fifo_count), 32'(1));
        bus.tx_valid = 1'b1;
        bus.tx_data  = vec[16].data;
        @(posedge clock_50M);
        #1;
        bus.tx_valid = 1'b0;
        chk("pp_count", 32'(fifo_count), 32'(1));
      end
      begin
        repeat (2) @(posedge clock_50M);
        #1;
        for (int k = 14; k < 17; k++) check_frame(k);
      end
    join
    chk("pp_end_count", 32'(fifo_count), 32'(0));
    repeat (3) @(posedge clock_50M);
    #1;
    // asynchronous reset in the middle of a data bit
    push_seq(17, 3, stalls, peak);
    chk("rstq_count", 32'(fifo_count), 32'(2));
    repeat (10) @(posedge clock_50M);
    #1;
    chk("rstq_busy", 32'(busy), 32'(1));
    #2 n_rst = 1'b0;
    #1;
    chk("midrst_tx", 32'(tx), 32'(1));
    chk("midrst_busy", 32'(busy), 32'(0));
    chk("midrst_count", 32'(fifo_count), 32'(0));
    chk("midrst_ready", 32'(bus.tx_ready), 32'(1));
    @(posedge clock_50M);
    #1 n_rst = 1'b1;
    for (int c = 0; c < 50; c++) begin
      chk("postrst_tx", 32'(tx), 32'(1));
      chk("postrst_busy", 32'(busy), 32'(0));
      @(posedge clock_50M);
      #1;
    end
    chk("postrst_count", 32'(fifo_count), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
